// File: rtl/tile_pkg.sv
// Shared constants, FSM encoding and sprite orientation codes for the tile table.
// Pure declarations: no latency, no flow control.
package tile_pkg;
  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int TILES = COLS * ROWS;
  localparam logic [DW-1:0] CLEAR_VAL = 8'd0;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_WRITE     = 5'b00010,
    ST_READ      = 5'b00100,
    ST_READ_WAIT = 5'b01000,
    ST_CLEAR     = 5'b10000
  } state_t;

  // Sprite code is {orientation[2:0], index[4:0]}; bit 2 of orientation selects mirroring.
  localparam logic [2:0] ORI_RIGHT        = 3'b000;
  localparam logic [2:0] ORI_DOWN         = 3'b001;
  localparam logic [2:0] ORI_UP           = 3'b010;
  localparam logic [2:0] ORI_LEFT         = 3'b011;
  localparam logic [2:0] ORI_MIRROR_RIGHT = 3'b100;
  localparam logic [2:0] ORI_MIRROR_DOWN  = 3'b101;
  localparam logic [2:0] ORI_MIRROR_UP    = 3'b110;
  localparam logic [2:0] ORI_MIRROR_LEFT  = 3'b111;

  function automatic logic [AW-1:0] tile_addr(input logic [5:0] x, input logic [5:0] y);
    return AW'(y) * AW'(COLS) + AW'(x);
  endfunction
endpackage

// File: rtl/tile_ram.sv
// Single-port tile storage, write-first, registered read data one cycle after the address.
// No flow control: one access per cycle, contents are never reset.
module tile_ram
  import tile_pkg::*;
#(
  parameter int DEPTH = TILES,
  parameter int RAW   = AW,
  parameter int RDW   = DW
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic [RAW-1:0] i_addr,
  input  logic [RDW-1:0] i_wdat,
  output logic [RDW-1:0] o_rdat
);
  logic [RDW-1:0] r_mem [DEPTH];
  logic [RDW-1:0] r_rdat;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdat;
      r_rdat        <= i_wdat;
    end else begin
      r_rdat <= r_mem[i_addr];
    end
  end

  assign o_rdat = r_rdat;
endmodule

// File: rtl/tile_table_ctrl.sv
// Tile table controller: edge-captured game writes/reads and clear sweeps share one RAM port.
// Video fetch wins the port every cycle it asks (1-cycle latency); game/clear work stalls meanwhile.
module tile_table_ctrl
  import tile_pkg::*;
(
  input  logic          px_clk,
  input  logic          rst,
  input  logic          update,
  input  logic          get,
  input  logic [5:0]    posx,
  input  logic [5:0]    posy,
  input  logic [DW-1:0] sprite,
  input  logic          clear,
  output logic [DW-1:0] read_sprite,
  output logic          ready,
  output logic          busy,
  output logic          err,
  input  logic          vid_rd,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_tile,
  output logic          vid_valid
);
  localparam logic [AW-1:0] CLR_LAST = AW'(TILES - 1);

  state_t        r_state, w_next;
  logic          r_upd_q, r_get_q, r_clr_q;
  logic          r_wr_pend, r_rd_pend;
  logic [AW-1:0] r_wr_addr, r_rd_addr, r_clr_addr;
  logic [DW-1:0] r_wr_dat, r_read_sprite, r_vid_hold;
  logic          r_ready, r_err, r_vid_valid;

  logic          w_upd_edge, w_get_edge, w_clr_edge, w_in_range;
  logic          w_upd_drop, w_get_drop, w_clr_drop, w_upd_take, w_get_take;
  logic [AW-1:0] w_req_addr, w_ram_addr;
  logic [DW-1:0] w_ram_wdat, w_ram_rdat;
  logic          w_ram_we, w_wr_done, w_rd_done, w_clr_step;

  assign w_upd_edge = update & ~r_upd_q;
  assign w_get_edge = get & ~r_get_q;
  assign w_clr_edge = clear & ~r_clr_q;
  assign w_in_range = (posx < 6'(COLS)) && (posy < 6'(ROWS));
  assign w_req_addr = w_in_range ? tile_addr(posx, posy) : '0;

  assign busy       = r_wr_pend | r_rd_pend | (r_state != ST_IDLE);
  assign w_upd_drop = w_upd_edge && ((r_state == ST_CLEAR) || !w_in_range || r_wr_pend);
  assign w_get_drop = w_get_edge && ((r_state == ST_CLEAR) || !w_in_range || r_rd_pend);
  assign w_clr_drop = w_clr_edge && busy;
  assign w_upd_take = w_upd_edge && !w_upd_drop;
  assign w_get_take = w_get_edge && !w_get_drop;

  always_comb begin
    w_next     = r_state;
    w_ram_we   = 1'b0;
    w_ram_addr = vid_addr;
    w_ram_wdat = r_wr_dat;
    w_wr_done  = 1'b0;
    w_rd_done  = 1'b0;
    w_clr_step = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_wr_pend)       w_next = ST_WRITE;
        else if (r_rd_pend)  w_next = ST_READ;
        else if (w_clr_edge) w_next = ST_CLEAR;
      end
      ST_WRITE: if (!vid_rd) begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_wr_addr;
        w_wr_done  = 1'b1;
        w_next     = ST_IDLE;
      end
      ST_READ: if (!vid_rd) begin
        w_ram_addr = r_rd_addr;
        w_next     = ST_READ_WAIT;
      end
      // RAM output already holds the game read issued last cycle, even if video now owns the port.
      ST_READ_WAIT: begin
        w_rd_done = 1'b1;
        w_next    = ST_IDLE;
      end
      ST_CLEAR: if (!vid_rd) begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_addr;
        w_ram_wdat = CLEAR_VAL;
        w_clr_step = 1'b1;
        if (r_clr_addr == CLR_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge px_clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_upd_q       <= 1'b0;
      r_get_q       <= 1'b0;
      r_clr_q       <= 1'b0;
      r_wr_pend     <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_clr_addr    <= '0;
      r_wr_dat      <= '0;
      r_read_sprite <= '0;
      r_vid_hold    <= '0;
      r_ready       <= 1'b0;
      r_err         <= 1'b0;
      r_vid_valid   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_upd_q     <= update;
      r_get_q     <= get;
      r_clr_q     <= clear;
      r_err       <= w_upd_drop | w_get_drop | w_clr_drop;
      r_ready     <= w_rd_done;
      r_vid_valid <= vid_rd;
      if (r_vid_valid) r_vid_hold    <= w_ram_rdat;
      if (w_rd_done)   r_read_sprite <= w_ram_rdat;
      if (w_upd_take) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= w_req_addr;
        r_wr_dat  <= sprite;
      end else if (w_wr_done) begin
        r_wr_pend <= 1'b0;
      end
      if (w_get_take) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= w_req_addr;
      end else if (w_rd_done) begin
        r_rd_pend <= 1'b0;
      end
      if (w_clr_step) r_clr_addr <= (r_clr_addr == CLR_LAST) ? '0 : r_clr_addr + 1'b1;
    end
  end

  tile_ram #(.DEPTH(TILES), .RAW(AW), .RDW(DW)) u_ram (
    .i_clk  (px_clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdat (w_ram_wdat),
    .o_rdat (w_ram_rdat)
  );

  // Between fetches the last fetched tile is held so the output never shows game/clear traffic.
  assign vid_tile    = r_vid_valid ? w_ram_rdat : r_vid_hold;
  assign vid_valid   = r_vid_valid;
  assign read_sprite = r_read_sprite;
  assign ready       = r_ready;
  assign err         = r_err;
endmodule

// File: tb/tb_tile_table_ctrl.sv
// Scoreboarded bench for tile_table_ctrl: directed scenarios plus random traffic against an array model.
module tb_tile_table_ctrl;
  import tile_pkg::*;

  logic          px_clk = 1'b0;
  logic          rst = 1'b0;
  logic          update = 1'b0, get = 1'b0, clear = 1'b0, vid_rd = 1'b0;
  logic [5:0]    posx = '0, posy = '0;
  logic [DW-1:0] sprite = '0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] read_sprite, vid_tile;
  logic          ready, busy, err, vid_valid;

  int n_chk = 0;
  int n_err = 0;
  int exp_err = 0;
  logic [7:0] model [TILES];
  logic [7:0] exp_rd_q [$];
  logic [7:0] exp_vid_q [$];

  tile_table_ctrl dut (
    .px_clk(px_clk), .rst(rst), .update(update), .get(get), .posx(posx), .posy(posy),
    .sprite(sprite), .clear(clear), .read_sprite(read_sprite), .ready(ready), .busy(busy),
    .err(err), .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_tile(vid_tile), .vid_valid(vid_valid)
  );

  always #5 px_clk = ~px_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge px_clk) begin
    if (rst) begin
      if (ready) begin
        if (exp_rd_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious_ready: read_sprite %0h with nothing expected", read_sprite);
        end else begin
          chk("read_sprite", 32'(read_sprite), 32'(exp_rd_q.pop_front()));
        end
      end
      if (vid_valid) begin
        if (exp_vid_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious_vid_valid: vid_tile %0h with nothing expected", vid_tile);
        end else begin
          chk("vid_tile", 32'(vid_tile), 32'(exp_vid_q.pop_front()));
        end
      end
      if (err) begin
        n_chk++;
        if (exp_err > 0) exp_err--;
        else begin
          n_err++;
          $display("FAIL spurious_err: err pulse %0b with no drop expected", err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    n_chk++;
    if (busy) begin
      n_err++;
      $display("FAIL wait_idle: busy %0b after %0d cycles", busy, budget);
    end
  endtask

  task automatic send_write(input int x, input int y, input logic [7:0] s, input bit slot_busy);
    posx = 6'(x); posy = 6'(y); sprite = s; update = 1'b1;
    tick();
    update = 1'b0;
    if (x >= COLS || y >= ROWS || slot_busy) exp_err++;
    else model[y*COLS + x] = s;
  endtask

  task automatic send_read(input int x, input int y);
    posx = 6'(x); posy = 6'(y); get = 1'b1;
    tick();
    get = 1'b0;
    if (x >= COLS || y >= ROWS) exp_err++;
    else exp_rd_q.push_back(model[y*COLS + x]);
  endtask

  task automatic vid_read(input int a);
    vid_rd = 1'b1; vid_addr = AW'(a);
    exp_vid_q.push_back(model[a]);
    tick();
    vid_rd = 1'b0;
  endtask

  initial begin
    int cnt;
    int op, x, y;
    #12;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_vid_valid", 32'(vid_valid), 0);
    chk("reset_read_sprite", 32'(read_sprite), 0);
    chk("reset_vid_tile", 32'(vid_tile), 0);
    @(negedge px_clk);
    rst = 1'b1;
    tick();

    // Clear sweep over pre-filled corners, with an update edge dropped mid-sweep.
    send_write(0, 0, 8'hFF, 0);   wait_idle(20);
    send_write(39, 29, 8'hFF, 0); wait_idle(20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 1300) begin
      if (cnt == 500) begin posx = 6'd1; posy = 6'd1; update = 1'b1; exp_err++; end
      if (cnt == 502) update = 1'b0;
      tick();
      cnt++;
    end
    chk("clear_busy_cycles", 32'(cnt), 1200);
    for (int i = 0; i < TILES; i++) model[i] = 8'h00;
    vid_read(0);
    vid_read(1199);
    tick();

    // Write then read with exact latency.
    send_write(5, 3, 8'h67, 0);
    chk("wr_busy_k", 32'(busy), 1);
    tick(); chk("wr_busy_k1", 32'(busy), 1);
    tick(); chk("wr_busy_k2", 32'(busy), 0);
    send_read(5, 3);
    chk("rd_ready_k", 32'(ready), 0);
    tick(); chk("rd_ready_k1", 32'(ready), 0);
    tick(); chk("rd_ready_k2", 32'(ready), 0);
    tick(); chk("rd_ready_k3", 32'(ready), 1);
    chk("rd_value_k3", 32'(read_sprite), 32'h67);
    chk("rd_busy_after", 32'(busy), 0);
    tick();

    // Range drops leave table and busy untouched.
    send_write(0, 1, 8'h3C, 0); wait_idle(20);
    send_write(40, 0, 8'h99, 0);
    chk("drop_busy_a", 32'(busy), 0);
    tick(); chk("drop_busy_b", 32'(busy), 0);
    vid_read(40);
    tick();
    send_read(3, 30);
    chk("drop_rd_busy", 32'(busy), 0);
    tick();

    // Update edge while its slot is still pending is dropped.
    send_write(7, 7, 8'h21, 0);
    tick();
    send_write(7, 7, 8'h42, 1);
    wait_idle(20);
    tick();
    vid_read(7*COLS + 7);
    tick();

    // Clear edge while busy is dropped and no sweep starts.
    send_write(8, 8, 8'h33, 0);
    clear = 1'b1; exp_err++;
    tick();
    clear = 1'b0;
    wait_idle(20);
    vid_read(8*COLS + 8);
    tick();

    // Video holds the port for 4 cycles while a write is pending.
    vid_rd = 1'b1; vid_addr = AW'(125);
    posx = 6'd5; posy = 6'd3; sprite = 8'h11; update = 1'b1;
    for (int i = 0; i < 4; i++) exp_vid_q.push_back(model[125]);
    tick();
    update = 1'b0;
    tick(); tick(); tick();
    chk("vid_stall_busy", 32'(busy), 1);
    vid_rd = 1'b0;
    tick();
    chk("vid_write_landed_busy", 32'(busy), 0);
    chk("vid_valid_drop", 32'(vid_valid), 0);
    model[125] = 8'h11;
    vid_read(125);
    tick();

    // Simultaneous update and get to the same tile.
    posx = 6'd2; posy = 6'd2; sprite = 8'hA5; update = 1'b1; get = 1'b1;
    tick();
    update = 1'b0; get = 1'b0;
    model[2*COLS + 2] = 8'hA5;
    exp_rd_q.push_back(8'hA5);
    wait_idle(20);
    tick(); tick();

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        x = int'($urandom_range(0, 43)); y = int'($urandom_range(0, 31));
        send_write(x, y, 8'($urandom_range(0, 255)), 0);
      end else if (op == 1) begin
        x = int'($urandom_range(0, 41)); y = int'($urandom_range(0, 30));
        send_read(x, y);
      end else begin
        vid_read(int'($urandom_range(0, TILES - 1)));
      end
      wait_idle(20);
      tick();
    end

    // Reset in the middle of a clear sweep.
    send_write(0, 15, 8'h5A, 0);  wait_idle(20);
    send_write(39, 29, 8'hC3, 0); wait_idle(20);
    send_write(39, 14, 8'h77, 0); wait_idle(20);
    send_read(0, 15); wait_idle(20);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (600) tick();
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(ready), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_vid_valid", 32'(vid_valid), 0);
    chk("arst_read_sprite", 32'(read_sprite), 0);
    chk("arst_vid_tile", 32'(vid_tile), 0);
    @(negedge px_clk);
    rst = 1'b1;
    for (int i = 0; i < 600; i++) model[i] = 8'h00;
    tick();
    chk("post_reset_busy", 32'(busy), 0);
    vid_read(599);
    vid_read(600);
    vid_read(1199);
    vid_read(0);
    tick(); tick(); tick();

    chk("rd_queue_left", 32'(exp_rd_q.size()), 0);
    chk("vid_queue_left", 32'(exp_vid_q.size()), 0);
    chk("err_pulses_missing", 32'(exp_err), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tile_table_ctrl.md
Name: tile_table_ctrl

Overview:
- Owns the 40x30 game tile table, indexed by tile column (posx) and row (posy).
- Consumes the single-tile write and read requests that the game-logic/FSM stage issues (update, get, posx, posy, sprite).
- Returns read_sprite and busy to that stage.
- Serves tile fetches from the video renderer. The video port always has priority on the single table port.

Parameters:
- COLS, 40, tile columns per row.
- ROWS, 30, tile rows.
- AW, 11, table address width (must satisfy 2^AW >= COLS*ROWS).
- DW, 8, sprite code width: {orientation[2:0], index[4:0]}.
- CLEAR_VAL, 8'd0, value written to every entry by a clear sweep.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- update  in  1  level write request from game logic; acted on at its rising edge.
- get  in  1  level read request; acted on at its rising edge.
- posx  in  6  tile column of the request.
- posy  in  6  tile row of the request.
- sprite  in  DW  data to write.
- clear  in  1  rising edge starts a full-table clear sweep.
- read_sprite  out  DW  result of the last completed read; held until the next read completes.
- ready  out  1  one-cycle pulse when read_sprite is updated.
- busy  out  1  high while any request is pending or executing.
- err  out  1  one-cycle pulse when a request is dropped.
- vid_rd  in  1  video fetch strobe.
- vid_addr  in  AW  linear tile address requested by video.
- vid_tile  out  DW  fetched tile; valid one cycle after vid_rd.
- vid_valid  out  1  vid_rd delayed by one cycle.

Behaviour:
- Reset values: state IDLE; busy, ready, err, vid_valid = 0; read_sprite, vid_tile = 0; update, get and clear edge-history registers = 0; both pending flags cleared. Table contents are not reset.
- Reset mid-operation aborts any write, read or clear immediately; partially cleared contents remain.
- Edge detection: a rising edge is the input sampled 1 at edge k after being sampled 0 at edge k-1. Each of update, get and clear has its own history register.
- Capture on an update edge: posx, posy and sprite are latched into a write slot; wr_pend is set.
- Capture on a get edge: posx and posy are latched into a read slot; rd_pend is set.
- Same-cycle update and get edges: both are captured. The write executes first, and the read returns the newly written value when the coordinates match.
- A request edge whose slot is already pending is ignored and err pulses.
- Any update or get edge during CLEAR is ignored and err pulses.
- Range check: posx >= COLS or posy >= ROWS drops the request at capture, pulses err and sets no pending flag.
- Address: addr = posy*COLS + posx, computed in AW bits from in-range operands only, so it never wraps.
- Port arbitration: when vid_rd = 1 at an edge, the table port serves vid_addr and any game or clear access stalls that cycle.
- Video read latency is 1: vid_tile and vid_valid update at the next edge.
- FSM states:
  - IDLE: go to WRITE if wr_pend, else READ if rd_pend, else CLEAR on a clear edge.
  - WRITE: when vid_rd = 0, write the table, clear wr_pend, go to IDLE.
  - READ: when vid_rd = 0, issue the address, go to READ_WAIT.
  - READ_WAIT: latch the data into read_sprite, pulse ready, clear rd_pend, go to IDLE.
  - CLEAR: write CLEAR_VAL at clr_addr on each cycle with vid_rd = 0, incrementing from 0. After writing COLS*ROWS-1 (1199), go to IDLE.
- Busy timing: busy = wr_pend | rd_pend | (state != IDLE). It rises at the capture edge.
- Minimum latencies with vid_rd = 0:
  - Write: update edge at k, IDLE->WRITE at k+1, table written at k+2, busy low after k+2.
  - Read: ready pulses at edge k+3.
- A clear edge arriving while busy is ignored and err pulses.

Decomposition:
- Shared package tile_pkg holds:
  - COLS, ROWS, AW, DW and CLEAR_VAL;
  - the state encoding (one-hot, 5 states);
  - orientation codes LEFT 3'b011, RIGHT 3'b000, UP 3'b010, DOWN 3'b001, and their MIRROR variants with bit 2 set.
- One sub-module, tile_ram: single-port synchronous RAM, COLS*ROWS x DW, one-cycle registered read, write-first. It has no reset.

Test Plan:
- Write then read, no video: update with (5,3) and sprite 8'h67; later get at (5,3). Required: addr 125 written; ready pulses exactly 3 cycles after the get edge; read_sprite = 8'h67; busy low afterwards.
- Range drop: update with posx = 40, posy = 0. Required: err pulses once, busy stays 0, entry 40 (tile (0,1)) unchanged.
- Video priority: hold vid_rd = 1 for 4 cycles with vid_addr = 125 while a write to (5,3) of 8'h11 is pending. Required: vid_valid follows vid_rd by one cycle with old data; the write lands on the first cycle vid_rd = 0; a following video read of 125 returns 8'h11.
- Simultaneous requests: update (2,2, 8'hA5) and get (2,2) edges in the same cycle. Required: write executes first; read_sprite = 8'hA5; a single ready pulse.
- Clear sweep: fill addresses 0 and 1199 with 8'hFF, then pulse clear. Required: busy high for 1200 cycles with vid_rd = 0; both entries read 0; an update edge mid-sweep pulses err.
- Reset mid-clear: drive rst = 0 at sweep count 600. Required: outputs reset asynchronously; entries at and above the interrupted address (600..1199) keep prior data.
